// File: rtl/ram_pkg.sv
// ram_pkg: shared constants, clear-engine state type and lane-width helper for ram_1w1r_pipe
package ram_pkg;
  localparam int COLL_READ_OLD = 0;
  localparam int COLL_WRITE_THRU = 1;
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  function automatic int lane_width(input int data_width, input int num_lanes);
    return data_width / num_lanes;
  endfunction
endpackage

// File: rtl/ram_lane_core.sv
// ram_lane_core: bare block-RAM array with per-lane masked write and registered read
module ram_lane_core
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 4096,
  parameter int DEPTH = 64,
  parameter int NUM_LANES = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [NUM_LANES-1:0]     wmask,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  localparam int LW = lane_width(DATA_WIDTH, NUM_LANES);
  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
  // masked lane write and registered read; a same-edge read returns the old word
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < NUM_LANES; i++)
        if (wmask[i]) mem[waddr][i*LW +: LW] <= wdata[i*LW +: LW];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ram_1w1r_pipe.sv
// ram_1w1r_pipe: 1W1R masked-write RAM with zero-fill engine, collision forwarding and 1/2-cycle read latency
module ram_1w1r_pipe
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 4096,
  parameter int DEPTH = 64,
  parameter int NUM_LANES = 512,
  parameter int READ_LATENCY = 1,
  parameter int COLLISION_MODE = 0,
  parameter int INIT_ON_RESET = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [NUM_LANES-1:0]     wr_mask,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  input  logic                     clr_start,
  output logic                     busy
);
  localparam int LW = lane_width(DATA_WIDTH, NUM_LANES);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  clr_state_t state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt, core_waddr, core_raddr;
  logic last, wr_ok, rd_ok, rd_oor, core_we, s1_v, s1_oor, s1_have;
  logic [NUM_LANES-1:0] fwd, s1_fwd, core_wmask;
  logic [DATA_WIDTH-1:0] core_wdata, q, s1_din, merged, s1_data;

  assign busy = state == CLEAR;
  assign last = cnt == AW'(DEPTH-1);
  assign wr_ok = wr_en && !busy && !rst && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok = rd_en && !busy && !rst;
  assign rd_oor = {1'b0, rd_addr} >= DEPTH_W;
  assign fwd = (COLLISION_MODE == COLL_WRITE_THRU && wr_ok && wr_addr == rd_addr) ? wr_mask : '0;
  assign core_we = (busy && !rst) || wr_ok;
  assign core_waddr = busy ? cnt : wr_addr;
  assign core_wmask = busy ? '1 : wr_mask;
  assign core_wdata = busy ? '0 : din;
  assign core_raddr = rd_oor ? '0 : rd_addr;

  ram_lane_core #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .NUM_LANES(NUM_LANES)) u_core (
    .clk(clk), .we(core_we), .waddr(core_waddr), .wmask(core_wmask), .wdata(core_wdata),
    .re(rd_ok), .raddr(core_raddr), .rdata(q)
  );

  // clear engine state and zero-fill address counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT_ON_RESET != 0 ? CLEAR : IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end

  // start on clr_start, walk every address once, stop after the last word
  always_comb begin
    state_nxt = busy ? (last ? IDLE : CLEAR) : (clr_start ? CLEAR : IDLE);
    cnt_nxt = busy && !last ? cnt + 1'b1 : '0;
  end

  // first read stage: capture the per-access forwarding and range decisions alongside the array read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s1_have <= 1'b0;
      s1_oor <= 1'b0;
      s1_fwd <= '0;
      s1_din <= '0;
    end else begin
      s1_v <= rd_ok;
      if (rd_ok) begin
        s1_have <= 1'b1;
        s1_oor <= rd_oor;
        s1_fwd <= fwd;
        s1_din <= din;
      end
    end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[i*LW +: LW] = s1_fwd[i] ? s1_din[i*LW +: LW] : q[i*LW +: LW];
  end
  assign s1_data = s1_have && !s1_oor ? merged : '0;

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data;
    logic s2_v;
    // second read stage: registered copy of the first-stage result
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        s2_v <= 1'b0;
        s2_data <= '0;
      end else begin
        s2_v <= s1_v;
        if (s1_v) s2_data <= s1_data;
      end
    assign dout = s2_data;
    assign dout_valid = s2_v;
  end else begin : g_lat1
    assign dout = s1_data;
    assign dout_valid = s1_v;
  end
endmodule

// File: doc/ram_1w1r_pipe.md
Name: ram_1w1r_pipe

Overview:
- Parametrised successor to the team's simple dual-port (1 write, 1 read) block-RAM wrapper.
- Adds byte-lane write masks, configurable read latency (1 or 2) with a valid flag, and a selectable same-address collision policy (read-old or write-through).
- Adds an internal clear engine that zero-fills the array on command or after reset.
- Sits between matrix-multiply MAC arrays and their operand/result buffers, where wide words are streamed with per-lane updates.

Parameters:
DATA_WIDTH, 4096, word width in bits; must be divisible by NUM_LANES
DEPTH, 64, number of words; need not be a power of two
NUM_LANES, 512, number of write-mask lanes; lane width = DATA_WIDTH/NUM_LANES
READ_LATENCY, 1, 1 or 2 clock edges from accepted read to dout_valid
COLLISION_MODE, 0, 0 = read returns old data; 1 = write-through (new data forwarded per written lane)
INIT_ON_RESET, 0, 1 = clear engine starts automatically when rst deasserts

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  reset, asynchronous and active-high
wr_en  in  1  write request
wr_addr  in  $clog2(DEPTH)  write address
wr_mask  in  NUM_LANES  per-lane write enable; lane i = din[i*LW +: LW]
din  in  DATA_WIDTH  write data
rd_en  in  1  read request
rd_addr  in  $clog2(DEPTH)  read address
dout  out  DATA_WIDTH  read data, held between reads
dout_valid  out  1  one-cycle pulse per accepted read, aligned with dout
clr_start  in  1  pulse to start zero-fill
busy  out  1  high while clear engine runs

Behaviour:
- Storage array is never reset. Reset only clears the control logic and the output registers.
- While rst=1:
  - dout=0, dout_valid=0, pipeline valids=0, clear counter=0.
  - FSM is forced to IDLE; busy=0.
  - If INIT_ON_RESET=1, FSM is instead forced to CLEAR with busy=1, and the zero-fill starts on the first edge after deassert.
- Reset asserted mid-clear aborts the clear. The array is left partially zeroed unless INIT_ON_RESET restarts it.
- Write on an edge with wr_en=1 and busy=0:
  - Only lanes with wr_mask[i]=1 are updated.
  - wr_mask=0 is a no-op.
  - wr_addr>=DEPTH is ignored.
- Read is accepted on an edge with rd_en=1 and busy=0.
  - READ_LATENCY=1: dout and dout_valid update on that same edge.
  - READ_LATENCY=2: one additional register stage; dout and dout_valid update on the next edge. Both stages are fully pipelined, so back-to-back reads give one result per cycle.
- rd_addr>=DEPTH: the read is still accepted; dout=0 and dout_valid=1.
- When no read is accepted, dout holds its last value and dout_valid=0.
- Collision (accepted read and write to the same in-range address on the same edge):
  - COLLISION_MODE=0: dout = prior contents.
  - COLLISION_MODE=1: lanes with wr_mask=1 come from din; other lanes come from the prior contents.
  - Forwarding decisions are made at the access edge and carried through the stage-2 register.
- Clear FSM states:
  - IDLE -> CLEAR on clr_start=1.
  - In CLEAR: each edge writes all-zero to counter address, then counter+1.
  - CLEAR -> IDLE on the edge that writes address DEPTH-1. Counter resets to 0; busy falls on that edge.
  - Clear takes exactly DEPTH cycles.
- While busy=1:
  - wr_en and rd_en are ignored (dropped, not queued).
  - clr_start is ignored.
  - Reads already in the stage-2 pipeline still complete.
- clr_start and wr_en together in IDLE: the write takes effect on that edge and CLEAR starts next. That word is zeroed later.

Decomposition:
- Shared package ram_pkg:
  - collision-mode constants COLL_READ_OLD=0 and COLL_WRITE_THRU=1;
  - clear FSM state typedef {IDLE, CLEAR};
  - helper function for lane width.
- One sub-module, ram_lane_core: the bare masked-write, registered-read array with ram_style block, a write port and a read port.
- The top level holds the clear FSM, write mux (clear vs user), collision forwarding, latency pipeline and out-of-range handling.

Test Plan:
- Reset, INIT_ON_RESET=0, DEPTH=64, LAT=1: write 0xA5.. to addr 3 with full mask; read addr 3 next cycle -> dout=0xA5.., dout_valid pulses one cycle after rd_en edge.
- Masked write: full write 0xFF..FF to addr 5; then write din=0 with wr_mask lane 0 only; read addr 5 -> lane 0 = 0, all other lanes 0xFF.
- Collision, write 0x11.. then same-edge write 0x22.. with read on addr 7: COLLISION_MODE=0 -> dout=0x11..; COLLISION_MODE=1 with half mask -> masked lanes 0x22, rest 0x11.
- LAT=2: rd_en high 4 cycles on addrs 0..3 -> 4 consecutive dout_valid beats starting 2 edges after first request, correct data order.
- Clear: fill all 64 words nonzero, pulse clr_start -> busy high exactly 64 cycles; reads/writes during busy produce no dout_valid or change; afterwards every address reads 0.
- DEPTH=48, reset mid-clear at count 20 with INIT_ON_RESET=1 -> busy stays high, clear restarts from 0, takes 48 cycles; read addr 50 -> dout=0, dout_valid=1.
